// File: rtl/iir_frame_sequencer.sv
// Frame sequencer for the cascaded-SOS IIR datapath. It opens a frame on
// start, forwards FRAME_LEN samples to the filter chain, numbers the filter
// outputs with a write address, and closes the frame on the last output or on
// a drain timeout. A sticky flag reports when consecutive outputs have settled.
//
// Handshake: every *_valid is a single-cycle strobe that qualifies its data in
// that same cycle. There is no ready/back-pressure in either direction, so a
// strobe arriving in a state that does not accept it is simply dropped.
module iir_frame_sequencer #(
  parameter int DATA_W        = 24,
  parameter int ADDR_W        = 11,
  parameter int FRAME_LEN     = 2048,
  parameter int STABLE_TOL    = 64,
  parameter int STABLE_CNT    = 16,
  parameter int DRAIN_TIMEOUT = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              fil_in_valid,
  output logic [DATA_W-1:0] fil_in_data,
  input  logic              fil_out_valid,
  input  logic [DATA_W-1:0] fil_out_data,
  output logic              data_out_valid,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] addr,
  output logic              filter_done,
  output logic              stable_out,
  output logic              busy,
  output logic              timeout_err,
  output logic [1:0]        dbg_state
);

  localparam int CNT_W  = $clog2(FRAME_LEN + 1);
  localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);
  localparam int SET_W  = $clog2(STABLE_CNT + 1);

  localparam logic [CNT_W-1:0]  LAST_IDX   = CNT_W'(FRAME_LEN - 1);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(DRAIN_TIMEOUT);
  localparam logic [SET_W-1:0]  SET_FULL   = SET_W'(STABLE_CNT);
  localparam logic [DATA_W:0]   TOL        = (DATA_W + 1)'(STABLE_TOL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]    out_cnt_q, out_cnt_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                have_prev_q, have_prev_d;
  logic                stable_q, stable_d;
  logic                timeout_q, timeout_d;
  logic                fil_in_valid_q, fil_in_valid_d;
  logic [DATA_W-1:0]   fil_in_data_q, fil_in_data_d;
  logic                dout_valid_q, dout_valid_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                done_q, done_d;

  // Sign-extended difference between the new output and the previous one;
  // DATA_W+1 bits cannot overflow, so the magnitude is exact.
  logic [DATA_W:0] diff;
  logic [DATA_W:0] diff_mag;
  logic            out_accept;

  assign diff       = {fil_out_data[DATA_W-1], fil_out_data} - {prev_q[DATA_W-1], prev_q};
  assign diff_mag   = diff[DATA_W] ? (~diff + (DATA_W + 1)'(1)) : diff;
  assign out_accept = fil_out_valid && ((state_q == S_RUN) || (state_q == S_DRAIN));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state, counters, forwarding and settle tracking.
  always_comb begin
    state_d        = state_q;
    in_cnt_d       = in_cnt_q;
    out_cnt_d      = out_cnt_q;
    idle_d         = idle_q;
    settle_d       = settle_q;
    prev_d         = prev_q;
    have_prev_d    = have_prev_q;
    stable_d       = stable_q;
    timeout_d      = timeout_q;
    fil_in_valid_d = 1'b0;
    fil_in_data_d  = fil_in_data_q;
    dout_valid_d   = 1'b0;
    dout_d         = dout_q;
    addr_d         = addr_q;
    done_d         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_RUN;
          in_cnt_d    = '0;
          out_cnt_d   = '0;
          idle_d      = '0;
          settle_d    = '0;
          have_prev_d = 1'b0;
          stable_d    = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      S_RUN: begin
        if (in_valid) begin
          fil_in_valid_d = 1'b1;
          fil_in_data_d  = in_data;
          in_cnt_d       = in_cnt_q + CNT_W'(1);
          if (in_cnt_q == LAST_IDX) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fil_out_valid) begin
          idle_d = '0;
        end else begin
          idle_d = idle_q + IDLE_W'(1);
          if (idle_d == IDLE_LIMIT) begin
            timeout_d = 1'b1;
            done_d    = 1'b1;
            state_d   = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs overlap inputs, so they are numbered in RUN as well as DRAIN.
    if (out_accept) begin
      dout_valid_d = 1'b1;
      dout_d       = fil_out_data;
      addr_d       = ADDR_W'(out_cnt_q);
      out_cnt_d    = out_cnt_q + CNT_W'(1);
      prev_d       = fil_out_data;
      have_prev_d  = 1'b1;
      if (have_prev_q) begin
        if (diff_mag <= TOL) settle_d = (settle_q == SET_FULL) ? settle_q : settle_q + SET_W'(1);
        else                 settle_d = '0;
      end
      stable_d = stable_q | (settle_d == SET_FULL);
      if (out_cnt_q == LAST_IDX) begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
    end
  end

  // Datapath and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_cnt_q       <= '0;
      out_cnt_q      <= '0;
      idle_q         <= '0;
      settle_q       <= '0;
      prev_q         <= '0;
      have_prev_q    <= 1'b0;
      stable_q       <= 1'b0;
      timeout_q      <= 1'b0;
      fil_in_valid_q <= 1'b0;
      fil_in_data_q  <= '0;
      dout_valid_q   <= 1'b0;
      dout_q         <= '0;
      addr_q         <= '0;
      done_q         <= 1'b0;
    end else begin
      in_cnt_q       <= in_cnt_d;
      out_cnt_q      <= out_cnt_d;
      idle_q         <= idle_d;
      settle_q       <= settle_d;
      prev_q         <= prev_d;
      have_prev_q    <= have_prev_d;
      stable_q       <= stable_d;
      timeout_q      <= timeout_d;
      fil_in_valid_q <= fil_in_valid_d;
      fil_in_data_q  <= fil_in_data_d;
      dout_valid_q   <= dout_valid_d;
      dout_q         <= dout_d;
      addr_q         <= addr_d;
      done_q         <= done_d;
    end
  end

  assign fil_in_valid   = fil_in_valid_q;
  assign fil_in_data    = fil_in_data_q;
  assign data_out_valid = dout_valid_q;
  assign data_out       = dout_q;
  assign addr           = addr_q;
  assign filter_done    = done_q;
  assign stable_out     = stable_q;
  assign timeout_err    = timeout_q;
  assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_iir_frame_sequencer.sv
// Directed bench for iir_frame_sequencer. Instance A (FRAME_LEN=8,
// DRAIN_TIMEOUT=10) is driven with an echoing filter model of 13 cycles
// latency; instance B (FRAME_LEN=32) is fed filter outputs directly to
// exercise the settle logic with STABLE_CNT=16.
module tb_iir_frame_sequencer;

  logic        clk;
  logic        rst_n;

  logic        start, in_valid, fil_out_valid;
  logic [23:0] in_data, fil_out_data;
  logic        fil_in_valid, data_out_valid, filter_done, stable_out, busy, timeout_err;
  logic [23:0] fil_in_data, data_out;
  logic [10:0] addr;
  logic [1:0]  dbg_state;

  logic        b_start, b_in_valid, b_fov;
  logic [23:0] b_in_data, b_fod;
  logic        b_fil_in_valid, b_dov, b_filter_done, b_stable_out, b_busy, b_timeout_err;
  logic [23:0] b_fil_in_data, b_data_out;
  logic [10:0] b_addr;
  logic [1:0]  b_dbg_state;

  int checks;
  int failures;

  // scoreboard / monitor state
  logic [23:0] exp_q[$];
  logic [23:0] got_in_q[$];
  logic [23:0] got_data_q[$];
  logic [10:0] got_addr_q[$];
  int          done_cnt, done_cycle, last_dout_cycle, cycle;
  logic        done_with_last, busy_at_done, tmo_at_done;

  // filter echo model
  logic        ev[13];
  logic [23:0] ed[13];
  int          echo_sent, echo_limit;

  iir_frame_sequencer #(
    .DATA_W(24), .ADDR_W(11), .FRAME_LEN(8), .STABLE_TOL(64),
    .STABLE_CNT(16), .DRAIN_TIMEOUT(10)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .fil_in_valid(fil_in_valid), .fil_in_data(fil_in_data),
    .fil_out_valid(fil_out_valid), .fil_out_data(fil_out_data),
    .data_out_valid(data_out_valid), .data_out(data_out), .addr(addr),
    .filter_done(filter_done), .stable_out(stable_out), .busy(busy),
    .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  iir_frame_sequencer #(
    .DATA_W(24), .ADDR_W(11), .FRAME_LEN(32), .STABLE_TOL(64),
    .STABLE_CNT(16), .DRAIN_TIMEOUT(10)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid), .in_data(b_in_data),
    .fil_in_valid(b_fil_in_valid), .fil_in_data(b_fil_in_data),
    .fil_out_valid(b_fov), .fil_out_data(b_fod),
    .data_out_valid(b_dov), .data_out(b_data_out), .addr(b_addr),
    .filter_done(b_filter_done), .stable_out(b_stable_out), .busy(b_busy),
    .timeout_err(b_timeout_err), .dbg_state(b_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [23:0] samp(input int k);
    return 24'(32'h0A0000 + k * 32'h1111);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic clear_echo();
    for (int i = 0; i < 13; i++) begin
      ev[i] = 1'b0;
      ed[i] = '0;
    end
    fil_out_valid = 1'b0;
    fil_out_data  = '0;
  endtask

  task automatic clear_mon(input int limit);
    exp_q.delete();
    got_in_q.delete();
    got_data_q.delete();
    got_addr_q.delete();
    done_cnt        = 0;
    done_cycle      = 0;
    last_dout_cycle = 0;
    done_with_last  = 1'b0;
    busy_at_done    = 1'b1;
    tmo_at_done     = 1'b0;
    echo_sent       = 0;
    echo_limit      = limit;
  endtask

  // advance one clock, sample instance A, then run the echo model
  task automatic tick();
    logic        v;
    logic [23:0] d;
    @(posedge clk);
    #1;
    cycle++;
    if (fil_in_valid) got_in_q.push_back(fil_in_data);
    if (data_out_valid) begin
      got_addr_q.push_back(addr);
      got_data_q.push_back(data_out);
      last_dout_cycle = cycle;
    end
    if (filter_done) begin
      done_cnt++;
      done_cycle     = cycle;
      done_with_last = data_out_valid && (addr == 11'd7);
      busy_at_done   = busy;
      tmo_at_done    = timeout_err;
    end
    v = ev[12];
    d = ed[12];
    for (int i = 12; i > 0; i--) begin
      ev[i] = ev[i-1];
      ed[i] = ed[i-1];
    end
    ev[0] = fil_in_valid;
    ed[0] = fil_in_data;
    if (v && echo_sent < echo_limit) begin
      fil_out_valid = 1'b1;
      fil_out_data  = d;
      echo_sent++;
    end else begin
      fil_out_valid = 1'b0;
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    start = 1'b0; in_valid = 1'b0; in_data = '0;
    b_start = 1'b0; b_in_valid = 1'b0; b_in_data = '0; b_fov = 1'b0; b_fod = '0;
    clear_echo();
    tick();
    tick();
    rst_n = 1'b1;
    clear_echo();
    tick();
  endtask

  task automatic drive_inputs(input int first_k, input int n, input int start_idx);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = samp(first_k + i);
      start    = (i == start_idx);
      tick();
    end
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 80) begin
      tick();
      n++;
    end
    check("done_seen", (done_cnt > 0), 1);
    tick(); tick(); tick();
    check("done_single", done_cnt, 1);
    check("idle_after", dbg_state, 0);
  endtask

  task automatic check_frame(input int first_k, input int n_out);
    logic [23:0] e;
    for (int i = 0; i < 8; i++) exp_q.push_back(samp(first_k + i));
    check("fwd_count", got_in_q.size(), 8);
    check("out_count", got_addr_q.size(), n_out);
    for (int i = 0; i < 8; i++) begin
      e = exp_q.pop_front();
      if (i < got_in_q.size()) check("fwd_data", got_in_q[i], e);
      if (i < n_out && i < got_addr_q.size()) begin
        check("out_addr", got_addr_q[i], i);
        check("out_data", got_data_q[i], e);
      end
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cycle    = 0;
    clear_mon(100);
    apply_reset();

    // reset state
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    check("rst_fil_in_valid", fil_in_valid, 0);
    check("rst_dout_valid", data_out_valid, 0);
    check("rst_addr", addr, 0);
    check("rst_done", filter_done, 0);
    check("rst_stable", stable_out, 0);
    check("rst_tmo", timeout_err, 0);

    // basic frame: 8 back-to-back inputs, echoed 13 cycles later
    clear_mon(100);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    drive_inputs(0, 8, -1);
    wait_done();
    check_frame(0, 8);
    check("done_with_addr7", done_with_last, 1);
    check("busy_at_done", busy_at_done, 0);
    check("tmo_clean_frame", tmo_at_done, 0);

    // settle tracking on instance B
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      b_fov = 1'b1;
      b_fod = 24'(i);
      tick();
    end
    check("st_after_ramp", b_stable_out, 0);
    for (int j = 1; j <= 20; j++) begin
      b_fod = 24'h100000;
      tick();
      if (j == 16) check("st_const16", b_stable_out, 0);
      if (j == 17) check("st_const17", b_stable_out, 1);
    end
    b_fod = 24'h100041;
    tick();
    check("st_sticky_step65", b_stable_out, 1);
    check("b_data_step", b_data_out, 24'h100041);
    check("b_addr_30", b_addr, 30);
    check("b_busy_run", b_busy, 1);
    tick();
    check("b_done_last", b_filter_done, 1);
    check("b_addr_31", b_addr, 31);
    b_fov = 1'b0;
    tick();
    check("b_idle", b_dbg_state, 0);
    b_start = 1'b1;
    tick();
    b_start = 1'b0;
    check("st_cleared_by_start", b_stable_out, 0);
    for (int i = 0; i <= 16; i++) begin
      b_fov = 1'b1;
      b_fod = 24'(i * 64);
      tick();
      if (i == 15) check("st_tol64_15", b_stable_out, 0);
      if (i == 16) check("st_tol64_16", b_stable_out, 1);
    end
    b_fov = 1'b0;

    // start together with first in_valid, then a second start mid-RUN
    clear_mon(100);
    start    = 1'b1;
    in_valid = 1'b1;
    in_data  = samp(9);
    tick();
    drive_inputs(10, 8, 3);
    wait_done();
    check_frame(10, 8);

    // 12 inputs offered: only 8 forwarded
    clear_mon(100);
    start = 1'b1;
    tick();
    start = 1'b0;
    drive_inputs(20, 12, -1);
    wait_done();
    check_frame(20, 8);

    // only 5 filter outputs: drain timeout
    clear_mon(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    drive_inputs(30, 8, -1);
    wait_done();
    check_frame(30, 5);
    check("tmo_set", tmo_at_done, 1);
    check("tmo_delay", done_cycle - last_dout_cycle, 10);
    check("tmo_busy", busy_at_done, 0);
    check("tmo_sticky", timeout_err, 1);
    clear_mon(100);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("tmo_cleared", timeout_err, 0);
    check("busy_new_frame", busy, 1);

    // reset mid-RUN, then a clean frame
    drive_inputs(40, 3, -1);
    check("pre_rst_fwd", fil_in_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_fil_in", fil_in_valid, 0);
    check("mid_rst_state", dbg_state, 0);
    check("mid_rst_fil_data", fil_in_data, 0);
    clear_echo();
    tick();
    tick();
    rst_n = 1'b1;
    clear_echo();
    tick();
    clear_mon(100);
    start = 1'b1;
    tick();
    start = 1'b0;
    drive_inputs(50, 8, -1);
    wait_done();
    check_frame(50, 8);
    check("post_rst_done_addr7", done_with_last, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
